// File: rtl/or2_checker_pkg.sv
// Shared definitions for the 2-input gate checker: FSM encoding,
// expected-function encodings and the size of the exhaustive vector set.
package or2_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [1:0] MODE_OR  = 2'd0;
   localparam logic [1:0] MODE_AND = 2'd1;
   localparam logic [1:0] MODE_XOR = 2'd2;
   localparam logic [1:0] MODE_NOR = 2'd3;

   // Every combination of a 2-input gate's inputs is exercised.
   localparam int         NUM_VEC  = 4;
   localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

endpackage

// File: rtl/gate_ref.sv
// Golden model of the gate under test: all four candidate functions are
// built from gate primitives and the latched mode selects one of them.
module gate_ref
   import or2_checker_pkg::*;
(
   input  logic [1:0] i_mode,
   input  logic       i_a,
   input  logic       i_b,
   output logic       o_y
);

   wire w_or;
   wire w_and;
   wire w_xor;
   wire w_nor;

   or  u_or  (w_or,  i_a, i_b);
   and u_and (w_and, i_a, i_b);
   xor u_xor (w_xor, i_a, i_b);
   nor u_nor (w_nor, i_a, i_b);

   // Pick the reference output for the selected gate function.
   always_comb begin
      o_y = w_or;
      case (i_mode)
         MODE_OR:  o_y = w_or;
         MODE_AND: o_y = w_and;
         MODE_XOR: o_y = w_xor;
         MODE_NOR: o_y = w_nor;
         default:  o_y = w_or;
      endcase
   end

endmodule

// File: rtl/or2_checker.sv
// Exhaustive checker for an external 2-input gate. A run drives the four
// input vectors 00,01,10,11 in order, waits SETTLE_CYC cycles for each to
// propagate, samples y_in against the reference function and records
// per-vector mismatches.
//
// Handshake: start is a level request that is only looked at in IDLE; the
// edge that sees start=1 in IDLE accepts the run and clears the results.
// done is a one-cycle pulse in the DONE state; pass/fail_vec/err_count are
// valid from that cycle and hold until the next accepted start.
module or2_checker
   import or2_checker_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [2:0] err_count,
   output state_t     dbg_state
);

   localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_idx;
   logic [1:0] r_mode;
   logic [3:0] r_settle_cnt;
   logic [3:0] r_fail_vec;
   logic [2:0] r_err_count;
   logic       r_pass;
   logic       w_y_exp;
   logic       w_mismatch;
   logic       w_drive_phase;

   gate_ref u_gate_ref (
      .i_mode (r_mode),
      .i_a    (r_idx[1]),
      .i_b    (r_idx[0]),
      .o_y    (w_y_exp)
   );

   assign w_mismatch    = (y_in != w_y_exp);
   assign w_drive_phase = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                          (r_state == ST_SAMPLE);

   // State register; reset wins over everything, including a run in flight.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: one DRIVE cycle, SETTLE_CYC settle cycles, one SAMPLE per vector.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_DRIVE;
         ST_DRIVE:  w_state_nxt = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
         ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
         ST_SAMPLE: w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_DRIVE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Run datapath: latch mode, step the vector index, accumulate mismatches.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 2'd0;
         r_mode       <= MODE_OR;
         r_settle_cnt <= 4'd0;
         r_fail_vec   <= 4'd0;
         r_err_count  <= 3'd0;
         r_pass       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode      <= mode;
                  r_idx       <= 2'd0;
                  r_fail_vec  <= 4'd0;
                  r_err_count <= 3'd0;
                  r_pass      <= 1'b0;
               end
            end
            ST_DRIVE:  r_settle_cnt <= 4'd0;
            ST_SETTLE: r_settle_cnt <= r_settle_cnt + 4'd1;
            ST_SAMPLE: begin
               if (w_mismatch) begin
                  r_fail_vec[r_idx] <= 1'b1;
                  r_err_count       <= r_err_count + 3'd1;
               end
               // The final vector's own result must be folded into pass.
               if (r_idx == LAST_IDX) r_pass <= (r_err_count == 3'd0) && !w_mismatch;
               else                   r_idx  <= r_idx + 2'd1;
            end
            ST_DONE:   r_idx <= 2'd0;
            default:   r_idx <= 2'd0;
         endcase
      end
   end

   // Outputs decoded from state; stimulus is forced to 00 outside a vector.
   always_comb begin
      a_out     = w_drive_phase ? r_idx[1] : 1'b0;
      b_out     = w_drive_phase ? r_idx[0] : 1'b0;
      busy      = (r_state != ST_IDLE);
      done      = (r_state == ST_DONE);
      pass      = r_pass;
      fail_vec  = r_fail_vec;
      err_count = r_err_count;
      dbg_state = r_state;
   end

endmodule

// File: tb/tb_or2_checker.sv
// Bench for or2_checker: two instances (SETTLE_CYC=1 and SETTLE_CYC=0) each
// driven by a behavioural model of the gate under test. Expected timing and
// results come from the run rules: each vector lasts SETTLE_CYC+2 cycles,
// done appears in cycle 4*(SETTLE_CYC+2)+1 after the accepting edge.
module tb_or2_checker;
   import or2_checker_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0;
   logic       start0 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       y1, y0;
   logic       a1, b1, busy1, done1, pass1;
   logic       a0, b0, busy0, done0, pass0;
   logic [3:0] fv1, fv0;
   logic [2:0] ec1, ec0;
   state_t     dbg1, dbg0;

   // Gate-under-test behaviour: 0=OR 1=AND 2=XOR 3=NOR 4=stuck0 5=stuck1
   logic [2:0] kind = 3'd0;
   bit         use_s0 = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [1:0] obs_ab;
   logic       obs_busy, obs_done, obs_pass;
   logic [3:0] obs_fv;
   logic [2:0] obs_ec;

   always #5 clk = ~clk;

   function automatic logic gate_fn(input logic [2:0] k, input logic a, input logic b);
      case (k)
         3'd0:    return a | b;
         3'd1:    return a & b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a | b);
         3'd4:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      y1 = gate_fn(kind, a1, b1);
      y0 = gate_fn(kind, a0, b0);
   end

   always_comb begin
      if (use_s0) begin
         obs_ab = {a0, b0}; obs_busy = busy0; obs_done = done0;
         obs_pass = pass0; obs_fv = fv0; obs_ec = ec0;
      end else begin
         obs_ab = {a1, b1}; obs_busy = busy1; obs_done = done1;
         obs_pass = pass1; obs_fv = fv1; obs_ec = ec1;
      end
   end

   or2_checker #(.SETTLE_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode), .y_in(y1),
      .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
      .fail_vec(fv1), .err_count(ec1), .dbg_state(dbg1)
   );

   or2_checker #(.SETTLE_CYC(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .mode(mode), .y_in(y0),
      .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
      .fail_vec(fv0), .err_count(ec0), .dbg_state(dbg0)
   );

   // One full run on the selected instance with per-cycle checking.
   task automatic run_and_check(input bit s0, input logic [2:0] k,
                                input logic [1:0] md, input string tag);
      int         len;
      int         tot;
      logic [3:0] exp_fv;
      logic [2:0] exp_ec;
      logic       exp_pass;
      logic [1:0] exp_ab;
      logic       exp_busy, exp_done;
      len    = s0 ? 2 : 3;
      tot    = 4 * len;
      exp_fv = 4'd0;
      exp_ec = 3'd0;
      for (int v = 0; v < 4; v++) begin
         logic [1:0] vv;
         vv = 2'(v);
         if (gate_fn(k, vv[1], vv[0]) != gate_fn({1'b0, md}, vv[1], vv[0])) begin
            exp_fv[v] = 1'b1;
            exp_ec    = exp_ec + 3'd1;
         end
      end
      exp_pass = (exp_ec == 3'd0);
      use_s0 = s0;
      kind   = k;
      @(negedge clk);
      mode = md;
      if (s0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      mode   = 2'($urandom_range(0, 3));
      for (int c = 1; c <= tot + 2; c++) begin
         @(negedge clk);
         if (c <= tot) begin
            exp_ab = 2'((c - 1) / len); exp_busy = 1'b1; exp_done = 1'b0;
         end else if (c == tot + 1) begin
            exp_ab = 2'd0; exp_busy = 1'b1; exp_done = 1'b1;
         end else begin
            exp_ab = 2'd0; exp_busy = 1'b0; exp_done = 1'b0;
         end
         total++;
         if ({obs_ab, obs_busy, obs_done} !== {exp_ab, exp_busy, exp_done}) begin
            bad++;
            $display("FAIL %s cyc%0d ctl: got ab=%b busy=%b done=%b want ab=%b busy=%b done=%b",
                     tag, c, obs_ab, obs_busy, obs_done, exp_ab, exp_busy, exp_done);
         end
         if (c == 1) begin
            total++;
            if ({obs_pass, obs_fv, obs_ec} !== 8'd0) begin
               bad++;
               $display("FAIL %s cleared: got pass=%b fv=%b ec=%0d want all 0",
                        tag, obs_pass, obs_fv, obs_ec);
            end
         end
         if (c >= tot + 1) begin
            total++;
            if ({obs_pass, obs_fv, obs_ec} !== {exp_pass, exp_fv, exp_ec}) begin
               bad++;
               $display("FAIL %s cyc%0d result: got pass=%b fv=%b ec=%0d want pass=%b fv=%b ec=%0d",
                        tag, c, obs_pass, obs_fv, obs_ec, exp_pass, exp_fv, exp_ec);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      start1 = 1'b1;
      start0 = 1'b1;
      mode   = 2'($urandom_range(0, 3));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         use_s0 = (i == 1);
         #1;
         total++;
         if ({obs_ab, obs_busy, obs_done, obs_pass, obs_fv, obs_ec} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs inst%0d: got ab=%b busy=%b done=%b pass=%b fv=%b ec=%0d want all 0",
                     i, obs_ab, obs_busy, obs_done, obs_pass, obs_fv, obs_ec);
         end
      end
      total++;
      if (dbg1 !== ST_IDLE || dbg0 !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d/%0d want %0d", dbg1, dbg0, ST_IDLE);
      end
      start1 = 1'b0;
      start0 = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ideal_or();
      run_and_check(1'b0, 3'd0, MODE_OR, "ideal_or");
   endtask

   task automatic test_stuck0();
      run_and_check(1'b0, 3'd4, MODE_OR, "stuck0");
      total++;
      if ({obs_fv, obs_ec, obs_pass} !== {4'b1110, 3'd3, 1'b0}) begin
         bad++;
         $display("FAIL stuck0_held: got fv=%b ec=%0d pass=%b want 1110 3 0", obs_fv, obs_ec, obs_pass);
      end
   endtask

   task automatic test_and_gate();
      run_and_check(1'b0, 3'd1, MODE_OR, "and_as_or");
      total++;
      if ({obs_fv, obs_ec, obs_pass} !== {4'b0110, 3'd2, 1'b0}) begin
         bad++;
         $display("FAIL and_as_or_held: got fv=%b ec=%0d pass=%b want 0110 2 0", obs_fv, obs_ec, obs_pass);
      end
      run_and_check(1'b0, 3'd1, MODE_AND, "and_as_and");
   endtask

   task automatic test_settle0();
      run_and_check(1'b1, 3'd0, MODE_OR, "settle0_or");
      run_and_check(1'b1, 3'd4, MODE_NOR, "settle0_nor");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         run_and_check(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)),
                       2'($urandom_range(0, 3)), $sformatf("rand%0d", n));
      end
   endtask

   task automatic test_reset_mid();
      use_s0 = 1'b0;
      kind   = 3'd0;
      @(negedge clk);
      mode   = MODE_OR;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      // start left high so the reset also has to win over a pending request
      for (int c = 1; c <= 7; c++) @(negedge clk);
      total++;
      if (obs_ab !== 2'b10 || obs_busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre: got ab=%b busy=%b want 10 1", obs_ab, obs_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({obs_ab, obs_busy, obs_done, obs_pass, obs_fv, obs_ec} !== 12'd0) begin
         bad++;
         $display("FAIL rst_mid_idle: got ab=%b busy=%b done=%b pass=%b fv=%b ec=%0d want all 0",
                  obs_ab, obs_busy, obs_done, obs_pass, obs_fv, obs_ec);
      end
      start1 = 1'b0;
      rst    = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_nodone cyc%0d: got done=%b busy=%b want 0 0", c, obs_done, obs_busy);
         end
      end
   endtask

   // start held high: runs accepted every 14 cycles (13 to done, 1 in IDLE).
   task automatic test_back_to_back();
      int         r;
      int         run;
      bit         act;
      logic [1:0] exp_ab;
      logic       exp_busy, exp_done;
      use_s0 = 1'b0;
      kind   = 3'd4;
      @(negedge clk);
      mode   = MODE_OR;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 46; c++) begin
         @(negedge clk);
         r        = (c - 1) % 14;
         run      = (c - 1) / 14;
         act      = (run <= 2);
         exp_done = act && (r == 12);
         exp_busy = act && (r != 13);
         exp_ab   = (act && r < 12) ? 2'(r / 3) : 2'd0;
         total++;
         if ({obs_ab, obs_busy, obs_done} !== {exp_ab, exp_busy, exp_done}) begin
            bad++;
            $display("FAIL b2b cyc%0d ctl: got ab=%b busy=%b done=%b want ab=%b busy=%b done=%b",
                     c, obs_ab, obs_busy, obs_done, exp_ab, exp_busy, exp_done);
         end
         if (act && r == 0) begin
            total++;
            if ({obs_pass, obs_fv, obs_ec} !== 8'd0) begin
               bad++;
               $display("FAIL b2b cyc%0d cleared: got pass=%b fv=%b ec=%0d want all 0",
                        c, obs_pass, obs_fv, obs_ec);
            end
         end
         if (act && r == 12) begin
            total++;
            if ({obs_pass, obs_fv, obs_ec} !== {1'b0, 4'b1110, 3'd3}) begin
               bad++;
               $display("FAIL b2b cyc%0d result: got pass=%b fv=%b ec=%0d want 0 1110 3",
                        c, obs_pass, obs_fv, obs_ec);
            end
         end
         if (c == 30) start1 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_ideal_or();
      test_stuck0();
      test_and_gate();
      test_settle0();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/or2_checker.md
OR2_CHECKER -- requirements
Module: or2_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, meaning idle cycles between driving a vector and sampling y_in (legal 0..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port mode  input  2  expected gate function: 0=OR, 1=AND, 2=XOR, 3=NOR.
REQ-006 SHALL have port y_in  input  1  response from 2-input gate under test.
REQ-007 SHALL have port a_out  output  1  stimulus to gate input a.
REQ-008 SHALL have port b_out  output  1  stimulus to gate input b.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 SHALL have port pass  output  1  1 when the last completed run had zero mismatches.
REQ-012 SHALL have port fail_vec  output  4  bit i set when vector i mismatched, i = {a,b}.
REQ-013 SHALL have port err_count  output  3  number of mismatches in the last run (0..4).

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL transition IDLE->DRIVE when start=1; mode latched and idx, fail_vec, err_count, pass cleared on that edge.
REQ-016 SHALL apply vectors in order idx 0..3, {a_out,b_out} = idx (00,01,10,11).
REQ-017 SHALL hold {a_out,b_out} = idx throughout DRIVE, SETTLE and SAMPLE; drive 00 in IDLE and DONE.
REQ-018 SHALL stay in DRIVE 1 cycle, SETTLE exactly SETTLE_CYC cycles (skipped when 0), SAMPLE 1 cycle.
REQ-019 SHALL, in SAMPLE, compare y_in with expected f(mode,a,b); on mismatch set fail_vec[idx] and increment err_count.
REQ-020 SHALL go SAMPLE->DRIVE with idx+1 when idx<3, and SAMPLE->DONE when idx=3 (no wrap).
REQ-021 SHALL stay in DONE 1 cycle with done=1, pass=(no mismatches), then return to IDLE.
REQ-022 SHALL assert done exactly 4*(SETTLE_CYC+2)+1 cycles after the edge that accepted start.
REQ-023 SHALL ignore start outside IDLE, including in DONE and while held high continuously mid-run.
REQ-024 SHALL hold pass, fail_vec, err_count after DONE until the next accepted start.
REQ-025 SHALL ignore mode changes after start acceptance.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, enter IDLE with a_out=0, b_out=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, idx=0.
REQ-027 SHALL let rst take priority over start and over any in-flight run; an aborted run SHALL never pulse done.

Structure
REQ-028 SHALL place the state encoding, mode encodings (MODE_OR/AND/XOR/NOR) and NUM_VEC=4 in shared package or2_checker_pkg.
REQ-029 SHALL compute the expected value in sub-module gate_ref, built from built-in or/and/xor/nor gate primitives plus a mode-select.

Verification
REQ-030 SHALL cover ideal OR gate as DUT, mode=0, SETTLE_CYC=1, start pulse -> a/b sequence 00,01,10,11; done at cycle 13; pass=1, fail_vec=0000, err_count=0.
REQ-031 SHALL cover y_in tied 0, mode=0 -> fail_vec=1110, err_count=3, pass=0.
REQ-032 SHALL cover AND gate as DUT, mode=0 -> fail_vec=0110, err_count=2, pass=0; rerun with mode=1 -> pass=1, fail_vec=0000.
REQ-033 SHALL cover rst asserted during vector idx=2 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-034 SHALL cover start held high for 30 cycles -> back-to-back runs, each done 13 cycles after acceptance, results cleared on each acceptance.
REQ-035 SHALL cover SETTLE_CYC=0 with ideal OR, mode=0 -> done at cycle 9, pass=1.
